fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Fetch-stage sequencer. Generates sequential PCs, issues in-order instruction requests to the icache, tags each response with its PC, and pushes {pc, inst} entries into the 16-entry fetch buffer.
- Does credit accounting so an accepted icache response always finds a free buffer slot; icache responses cannot be back-pressured.
- On redirect (branch flush, exception, ertn), discards stale in-flight responses and restarts fetching at the new PC.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset
- BUF_DEPTH, 16, fetch buffer entry count
- MAX_OUTSTANDING, 4, max icache requests in flight (live plus stale)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- redirect  in  1  one-cycle pulse (flush | excp_flush | ertn_flush); the fetch buffer is cleared in the same cycle
- redirect_pc  in  32  new fetch PC, valid with redirect
- req_valid  out  1  icache request valid
- req_addr  out  32  request PC, word-aligned
- req_ready  in  1  icache accepts request
- resp_valid  in  1  icache response; in order, never stalled
- resp_inst  in  32  instruction word
- resp_excp  in  1  fetch exception flag
- resp_excp_num  in  4  exception code
- push_valid  out  1  drives buffer left_valid
- push_bus  out  64  {pc[31:0], inst[31:0]}
- push_excp  out  5  {excp_num, excp}
- push_ready  in  1  buffer left_ready; checked only, never required
- pop  in  1  buffer fire (entry consumed)

Behaviour:
- Reset values:
  - state=FETCH, fetch_pc=req_addr=RESET_PC, resp_pc=RESET_PC
  - inflight=0, drop_cnt=0, occ=0
  - req_valid=0 during reset; push_valid=0, push_bus=0, push_excp=0
- States:
  - FETCH: requests are issued.
  - HALT: entered when an entry with resp_excp=1 is pushed. No further requests; live responses still in flight are still pushed. Exit to FETCH only on redirect.
- Issue rule: req_valid = (state==FETCH) & !redirect & (inflight < MAX_OUTSTANDING) & (occ + (inflight - drop_cnt) < BUF_DEPTH).
  - Handshake: req_valid & req_ready → fetch_pc += 4 and inflight += 1.
  - req_addr = fetch_pc; held stable while req_valid & !req_ready.
- Response with drop_cnt > 0: response discarded, drop_cnt -= 1, inflight -= 1.
- Response with drop_cnt == 0:
  - push_valid=1 in the same cycle (combinational, zero latency), push_bus={resp_pc, resp_inst}, push_excp={resp_excp_num, resp_excp}.
  - Then resp_pc += 4, inflight -= 1, occ += 1.
- pop → occ -= 1. Simultaneous push and pop leaves occ unchanged.
- Redirect, highest priority below reset:
  - fetch_pc ← redirect_pc, resp_pc ← redirect_pc, occ ← 0, state ← FETCH.
  - drop_cnt ← inflight − (resp_valid ? 1 : 0). Every remaining in-flight request becomes stale.
  - A response arriving in the redirect cycle is not pushed and decrements inflight.
  - pop in the redirect cycle is ignored.
- Widths:
  - inflight and drop_cnt are clog2(MAX_OUTSTANDING+1) bits.
  - occ is clog2(BUF_DEPTH+1) bits.
  - PC arithmetic wraps mod 2^32.
- Invariant (assertion): push_valid → push_ready. Violation is a design bug.
- Boundaries:
  - occ + live = BUF_DEPTH → no request.
  - inflight = MAX → no request, including when all in-flight are stale.
  - Redirect while the icache is stalling a request: request withdrawn, next cycle reissued at redirect_pc.
  - Reset mid-operation: all counters cleared. The icache is reset in the same cycle, so no stale responses remain.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum {FETCH, HALT}
  - RESET_PC constant
  - push_bus layout constants (PC_MSB=63, PC_LSB=32, INST_MSB=31)
  - excp bus width 5
- Sub-module `fetch_credit_cnt`: up/down counter with synchronous clear and saturating-range assertions. Instantiated twice, for occ and inflight.
- drop_cnt and PC logic stay inline.

Test Plan:
- Boot stream: req_ready=1, resp_valid one cycle after each request, pop=0 → requests at 1c000000..1c00003c. The 16 pushes have push_bus[63:32] = each address in order. req_valid then stays 0 with occ=16.
- Back-pressure refill: from the full state above, pulse pop once → exactly one new request at 1c000040. Its response is pushed with pc 1c000040.
- Outstanding cap: req_ready=1, responses withheld → exactly 4 requests (1c000000..1c00000c). Then req_valid=0 until the first response arrives.
- Redirect with 3 in flight: redirect_pc=1c001000 → next 3 responses dropped (no push_valid). Next request at 1c001000; first pushed pc=1c001000.
- Redirect in the same cycle as a response, inflight=2 → that response not pushed, drop_cnt=1. Only the second old response is dropped afterwards.
- Exception halt: response with resp_excp=1, resp_excp_num=4'h3 → push_excp=5'b00111, state HALT, req_valid=0. Redirect to 1c002000 resumes fetching there.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, reset PC, push bus layout.
// No logic here; zero latency, no backpressure.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  localparam int PC_MSB   = 63;
  localparam int PC_LSB   = 32;
  localparam int INST_MSB = 31;
  localparam int EXCP_W   = 5;

endpackage

// File: rtl/fetch_credit_cnt.sv
// Up/down credit counter with synchronous clear; one-cycle update latency.
// No backpressure: the caller must never step past 0 or MAX, which the assertions enforce.
module fetch_credit_cnt #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - W'(1);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (clr)
    (inc && !dec) |-> (cnt < W'(MAX)));

  a_no_underflow : assert property (@(posedge clk) disable iff (clr)
    (dec && !inc) |-> (cnt != '0));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: in-order icache requests, responses pushed to the fetch buffer in the same cycle.
// Requests throttle on outstanding cap and buffer credits; responses are never stalled.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = fetch_pkg::RESET_PC,
  parameter int          BUF_DEPTH       = 16,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_inst,
  input  logic        resp_excp,
  input  logic [3:0]  resp_excp_num,
  output logic        push_valid,
  output logic [63:0] push_bus,
  output logic [4:0]  push_excp,
  input  logic        push_ready,
  input  logic        pop
);

  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int PW = OW + 1;

  state_t         state, state_nxt;
  logic [31:0]    fetch_pc, resp_pc;
  logic [IW-1:0]  inflight, drop_cnt;
  logic [OW-1:0]  occ;
  logic [PW-1:0]  committed;
  logic           req_fire;

  // Slots already claimed: entries in the buffer plus live (non-stale) requests in flight.
  assign committed = PW'(occ) + PW'(inflight - drop_cnt);

  assign req_valid = !reset && (state == FETCH) && !redirect
                   && (inflight < IW'(MAX_OUTSTANDING))
                   && (committed < PW'(BUF_DEPTH));
  assign req_addr  = {fetch_pc[31:2], 2'b00};
  assign req_fire  = req_valid && req_ready;

  assign push_valid = !reset && resp_valid && !redirect && (drop_cnt == '0);
  assign push_bus[PC_MSB:PC_LSB] = push_valid ? resp_pc : '0;
  assign push_bus[INST_MSB:0]    = push_valid ? resp_inst : '0;
  assign push_excp = push_valid ? {resp_excp_num, resp_excp} : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FETCH;
    end else if (push_valid && resp_excp) begin
      state_nxt = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      // A response landing this cycle retires one of the old requests right now.
      drop_cnt <= inflight - IW'(resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push_valid) begin
        resp_pc <= resp_pc + 32'd4;
      end
      if (resp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - IW'(1);
      end
    end
  end

  fetch_credit_cnt #(.MAX(BUF_DEPTH), .W(OW)) u_occ (
    .clk (clk),
    .clr (reset || redirect),
    .inc (push_valid),
    .dec (pop && !redirect),
    .cnt (occ)
  );

  fetch_credit_cnt #(.MAX(MAX_OUTSTANDING), .W(IW)) u_inflight (
    .clk (clk),
    .clr (reset),
    .inc (req_fire),
    .dec (resp_valid),
    .cnt (inflight)
  );

  a_push_has_room : assert property (@(posedge clk) disable iff (reset)
    push_valid |-> push_ready);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a one-cycle in-order icache model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC   = 32'h1c00_0000;
  localparam logic [31:0] INST_KEY = 32'h0bad_f00d;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        resp_excp;
  logic [3:0]  resp_excp_num;
  logic        push_valid;
  logic [63:0] push_bus;
  logic [4:0]  push_excp;
  logic        push_ready;
  logic        pop;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_inst     (resp_inst),
    .resp_excp     (resp_excp),
    .resp_excp_num (resp_excp_num),
    .push_valid    (push_valid),
    .push_bus      (push_bus),
    .push_excp     (push_excp),
    .push_ready    (push_ready),
    .pop           (pop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic [31:0] exp_req, exp_pc, excp_addr;
  logic        resp_en;
  int          n_req, n_push, n_drop, drop_left;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    redirect   = 1'b0;
    pop        = 1'b0;
    resp_valid = 1'b0;
    resp_inst  = 32'h0;
    resp_excp  = 1'b0;
    resp_excp_num = 4'h0;
    @(posedge clk); #1;
    chk("rst_req_valid",  64'(req_valid),  64'(1'b0));
    chk("rst_push_valid", 64'(push_valid), 64'(1'b0));
    chk("rst_push_bus",   push_bus,        64'h0);
    chk("rst_push_excp",  64'(push_excp),  64'(5'h00));
    chk("rst_req_addr",   64'(req_addr),   64'(RST_PC));
    @(posedge clk); #1;
    reset     = 1'b0;
    q.delete();
    exp_req   = RST_PC;
    exp_pc    = RST_PC;
    excp_addr = 32'h0;
    n_req     = 0;
    n_push    = 0;
    n_drop    = 0;
    drop_left = 0;
  endtask

  // One clock: drive the icache model, check outputs, advance, clear pulses.
  task automatic cycle();
    logic [31:0] head;
    head          = (q.size() > 0) ? q[0] : 32'h0;
    resp_valid    = resp_en && (q.size() > 0);
    resp_inst     = resp_valid ? (head ^ INST_KEY) : 32'h0;
    resp_excp     = resp_valid && (head == excp_addr);
    resp_excp_num = resp_excp ? 4'h3 : 4'h0;
    #1;
    if (redirect) chk("req_withdrawn", 64'(req_valid), 64'(1'b0));
    if (req_valid) chk("req_addr", 64'(req_addr), 64'(exp_req));
    if (resp_valid) begin
      if (redirect || drop_left > 0) begin
        chk("stale_dropped", 64'(push_valid), 64'(1'b0));
        n_drop++;
        if (!redirect) drop_left--;
      end else begin
        chk("push_valid", 64'(push_valid), 64'(1'b1));
        chk("push_pc",    64'(push_bus[63:32]), 64'(exp_pc));
        chk("push_inst",  64'(push_bus[31:0]),  64'(head ^ INST_KEY));
        chk("push_excp",  64'(push_excp), resp_excp ? 64'(5'b00111) : 64'(5'b00000));
        exp_pc += 32'd4;
        n_push++;
      end
      void'(q.pop_front());
    end else begin
      chk("no_push", 64'(push_valid), 64'(1'b0));
    end
    if (req_valid && req_ready) begin
      q.push_back(exp_req);
      exp_req += 32'd4;
      n_req++;
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    pop      = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    redirect_pc = 32'h0;
    req_ready   = 1'b1;
    push_ready  = 1'b1;
    resp_en     = 1'b1;
    do_reset();

    // Boot stream fills the buffer, then requests stop at 16 entries.
    run(22);
    chk("boot_reqs",   64'(n_req),     64'(16));
    chk("boot_pushes", 64'(n_push),    64'(16));
    chk("full_no_req", 64'(req_valid), 64'(1'b0));

    // One pop frees one slot: exactly one request at 1c000040.
    pop = 1'b1;
    run(5);
    chk("refill_reqs",   64'(n_req),  64'(17));
    chk("refill_pushes", 64'(n_push), 64'(17));
    chk("refill_pc",     64'(exp_pc), 64'(32'h1c00_0044));
    chk("refill_idle",   64'(req_valid), 64'(1'b0));

    // Outstanding cap of four with responses withheld.
    do_reset();
    resp_en = 1'b0;
    run(8);
    chk("cap_reqs",    64'(n_req),     64'(4));
    chk("cap_no_req",  64'(req_valid), 64'(1'b0));
    resp_en = 1'b1;
    cycle();
    chk("cap_hold_reqs", 64'(n_req),  64'(4));
    chk("cap_first_push", 64'(n_push), 64'(1));
    cycle();
    chk("cap_reissue", 64'(n_req), 64'(5));

    // Redirect with three in flight while a fourth request is stalled.
    do_reset();
    resp_en = 1'b0;
    run(3);
    req_ready = 1'b0;
    run(2);
    chk("stall_req_valid", 64'(req_valid), 64'(1'b1));
    chk("stall_addr",      64'(req_addr),  64'(32'h1c00_000c));
    redirect = 1'b1; redirect_pc = 32'h1c00_1000;
    exp_req = 32'h1c00_1000; exp_pc = 32'h1c00_1000; drop_left = 3;
    cycle();
    req_ready = 1'b1;
    resp_en   = 1'b1;
    run(8);
    chk("redir3_drops", 64'(n_drop), 64'(3));
    chk("redir3_left",  64'(drop_left), 64'(0));
    chk("redir3_pushes", 64'(n_push), 64'(5));

    // Redirect coinciding with a response, two in flight.
    do_reset();
    resp_en = 1'b0;
    run(2);
    req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h1c00_1800;
    exp_req = 32'h1c00_1800; exp_pc = 32'h1c00_1800; drop_left = 1;
    resp_en = 1'b1;
    cycle();
    chk("redir_same_drop", 64'(n_drop), 64'(1));
    req_ready = 1'b1;
    run(8);
    chk("redir2_drops",  64'(n_drop), 64'(2));
    chk("redir2_pushes", 64'(n_push), 64'(7));

    // Exception on the third word halts fetch until a redirect.
    do_reset();
    excp_addr = RST_PC + 32'd8;
    run(7);
    chk("halt_reqs",   64'(n_req),     64'(4));
    chk("halt_pushes", 64'(n_push),    64'(4));
    chk("halt_no_req", 64'(req_valid), 64'(1'b0));
    redirect = 1'b1; redirect_pc = 32'h1c00_2000;
    exp_req = 32'h1c00_2000; exp_pc = 32'h1c00_2000;
    cycle();
    run(3);
    chk("resume_reqs",   64'(n_req),  64'(7));
    chk("resume_pushes", 64'(n_push), 64'(6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
